// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline.
// Holds the EX/MEM register, resolves branches and owns the data memory,
// whose latency is set by MEM_LATENCY. It stalls upstream while an access
// is still in flight and then drives the MEM/WB register for write-back.
module mem_stage #(
    parameter int DEPTH       = 256,
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] address,
    input  logic        zero,
    input  logic [31:0] resultOut,
    input  logic [31:0] pcout,
    input  logic        branch,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] write_data,
    input  logic        reg_write,
    input  logic        mem_to_reg,
    input  logic [4:0]  rd,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        misaligned,
    output logic        wb_valid,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_pcout,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg
);

    localparam int AW = $clog2(DEPTH);
    // Counter only has to reach MEM_LATENCY-1.
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

    typedef struct packed {
        logic        valid;
        logic [31:0] address;
        logic        zero;
        logic [31:0] result;
        logic [31:0] pcout;
        logic        branch;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] write_data;
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  rd;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [31:0] pcout;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
    } mem_wb_t;

    typedef enum logic {IDLE, BUSY} state_t;

    ex_mem_t         ex_mem_d, ex_mem_q;
    mem_wb_t         mem_wb_d, mem_wb_q;
    state_t          state_d, state_q;
    logic [CW-1:0]   cnt_d, cnt_q;
    logic            mem_op, aligned_op, store_en;
    logic [AW-1:0]   word_idx;

    // The array is deliberately left out of reset; the zero fill only gives
    // simulation a defined starting image.
    logic [31:0] mem_array [DEPTH] = '{default: '0};

    // Decode the instruction held in EX/MEM and work out whether the stage is stalled.
    always_comb begin
        mem_op     = ex_mem_q.valid & (ex_mem_q.mem_read | ex_mem_q.mem_write);
        misaligned = mem_op & (ex_mem_q.result[1:0] != 2'b00);
        aligned_op = mem_op & ~misaligned;
        // Upper address bits are ignored, so accesses wrap modulo DEPTH*4 bytes.
        word_idx   = ex_mem_q.result[AW+1:2];
        stall      = ((state_q == IDLE) && aligned_op && (MEM_LATENCY > 1)) ||
                     ((state_q == BUSY) && (cnt_q < CNT_LAST));
        // A store reaches the array only on its last (non-stalled) cycle.
        store_en   = aligned_op & ex_mem_q.mem_write & ~stall;
        pc_src        = ex_mem_q.valid & ex_mem_q.branch & ex_mem_q.zero;
        branch_target = ex_mem_q.address;
    end

    // Latency FSM: count the cycles an aligned access has spent in MEM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (aligned_op && (MEM_LATENCY > 1)) begin
                    state_d = BUSY;
                    cnt_d   = CW'(1);
                end
            end
            BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Next values for the EX/MEM and MEM/WB pipeline registers.
    always_comb begin
        ex_mem_d = ex_mem_q;
        if (!stall) begin
            ex_mem_d = '{valid: ex_valid, address: address, zero: zero,
                         result: resultOut, pcout: pcout, branch: branch,
                         mem_read: mem_read, mem_write: mem_write,
                         write_data: write_data, reg_write: reg_write,
                         mem_to_reg: mem_to_reg, rd: rd};
        end
        mem_wb_d = mem_wb_q;
        if (stall) begin
            // Send a bubble to WB and leave the data fields as they are.
            mem_wb_d.valid     = 1'b0;
            mem_wb_d.reg_write = 1'b0;
        end else begin
            mem_wb_d.valid      = ex_mem_q.valid;
            // Loads read the old word, even when they also store to it.
            mem_wb_d.read_data  = (aligned_op && ex_mem_q.mem_read) ? mem_array[word_idx] : 32'h0;
            mem_wb_d.alu_result = ex_mem_q.result;
            mem_wb_d.pcout      = ex_mem_q.pcout;
            mem_wb_d.rd         = ex_mem_q.rd;
            mem_wb_d.reg_write  = ex_mem_q.valid & ex_mem_q.reg_write & ~misaligned;
            mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
        end
    end

    // Pipeline registers and FSM state, all cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_mem_q <= '0;
            mem_wb_q <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

    // Data-memory write port; reset drops any store still pending.
    always_ff @(posedge clk) begin
        if (!reset && store_en) begin
            mem_array[word_idx] <= ex_mem_q.write_data;
        end
    end

    assign wb_valid      = mem_wb_q.valid;
    assign wb_read_data  = mem_wb_q.read_data;
    assign wb_alu_result = mem_wb_q.alu_result;
    assign wb_pcout      = mem_wb_q.pcout;
    assign wb_rd         = mem_wb_q.rd;
    assign wb_reg_write  = mem_wb_q.reg_write;
    assign wb_mem_to_reg = mem_wb_q.mem_to_reg;

endmodule
